// File: rtl/bullet_pkg.sv
// Shared types and constants for the player bullet motion logic.
package bullet_pkg;

   typedef enum logic [1:0] {IDLE, FLYING, COOLDOWN} bullet_state_t;

   localparam logic [9:0] DEFAULT_PARK_XY = 10'd1000;
   localparam logic [9:0] SPAWN_DX        = 10'd4;
   localparam logic [9:0] SPAWN_DY        = 10'd4;

endpackage

// File: rtl/frame_tick_sync.sv
// Brings the asynchronous vsync into the Clk domain and turns each rising
// edge into a single-cycle frame_tick pulse.
module frame_tick_sync (
   input  logic Clk,
   input  logic Reset,
   input  logic frame_clk,
   output logic frame_tick
);

   logic s1, s2, s2_prev;

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples the pre-edge value of its neighbour, forming a real shift chain.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         s1      <= 1'b0;
         s2      <= 1'b0;
         s2_prev <= 1'b0;
      end else begin
         s1      <= frame_clk;
         s2      <= s1;
         s2_prev <= s2;
      end
   end

   assign frame_tick = s2 & ~s2_prev;

endmodule

// File: rtl/bullet_controller.sv
// Launches, flies and retires the single player bullet at frame rate, with a
// cooldown between shots; parks the bullet off-screen whenever it is not live.
module bullet_controller
   import bullet_pkg::*;
#(
   parameter int unsigned STEP            = 4,
   parameter int unsigned Y_MIN           = 0,
   parameter int unsigned COOLDOWN_FRAMES = 8,
   parameter logic [9:0]  PARK_XY         = DEFAULT_PARK_XY
) (
   input  logic       Clk,
   input  logic       Reset,
   input  logic       frame_clk,
   input  logic       fire,
   input  logic       target_hit,
   input  logic [9:0] ShooterX,
   input  logic [9:0] ShooterY,
   output logic [9:0] BulletX,
   output logic [9:0] BulletY,
   output logic       bullet_active,
   output logic [7:0] shots_fired
);

   localparam int           CD_W    = (COOLDOWN_FRAMES > 1) ? $clog2(COOLDOWN_FRAMES) : 1;
   localparam logic [CD_W-1:0] CD_LOAD = CD_W'(COOLDOWN_FRAMES - 1);
   localparam logic [9:0]   STEP_V  = 10'(STEP);
   localparam logic [10:0]  Y_LIMIT = 11'(Y_MIN + STEP);

   bullet_state_t   state, state_n;
   logic [9:0]      x_n, y_n;
   logic [7:0]      shots_n;
   logic [CD_W-1:0] cd_cnt, cd_n;
   logic            fire_prev, fire_pending, fire_pending_n;
   logic            hit_pending, hit_pending_n;
   logic            frame_tick, fire_edge;
   logic [9:0]      spawn_x, spawn_y;

   frame_tick_sync u_tick (
      .Clk        (Clk),
      .Reset      (Reset),
      .frame_clk  (frame_clk),
      .frame_tick (frame_tick)
   );

   assign fire_edge = fire & ~fire_prev;
   assign spawn_x   = ShooterX + SPAWN_DX;
   assign spawn_y   = (ShooterY < SPAWN_DY) ? 10'd0 : ShooterY - SPAWN_DY;

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state        <= IDLE;
         BulletX      <= PARK_XY;
         BulletY      <= PARK_XY;
         shots_fired  <= 8'd0;
         cd_cnt       <= '0;
         fire_prev    <= 1'b0;
         fire_pending <= 1'b0;
         hit_pending  <= 1'b0;
      end else begin
         state        <= state_n;
         BulletX      <= x_n;
         BulletY      <= y_n;
         shots_fired  <= shots_n;
         cd_cnt       <= cd_n;
         fire_prev    <= fire;
         fire_pending <= fire_pending_n;
         hit_pending  <= hit_pending_n;
      end
   end

   // NOTE: every signal assigned here gets a default first, so no path
   // through the case leaves it unassigned and no latch is inferred.
   always_comb begin
      state_n        = state;
      x_n            = BulletX;
      y_n            = BulletY;
      shots_n        = shots_fired;
      cd_n           = cd_cnt;
      fire_pending_n = 1'b0;
      hit_pending_n  = 1'b0;

      unique case (state)
         IDLE: begin
            fire_pending_n = fire_pending | fire_edge;
            if (frame_tick && fire_pending) begin
               // Launch clears the pending request even if a new edge lands now.
               state_n        = FLYING;
               x_n            = spawn_x;
               y_n            = spawn_y;
               shots_n        = shots_fired + 8'd1;
               fire_pending_n = 1'b0;
            end
         end
         FLYING: begin
            hit_pending_n = hit_pending | target_hit;
            if (frame_tick) begin
               if (hit_pending || target_hit || ({1'b0, BulletY} < Y_LIMIT)) begin
                  state_n       = COOLDOWN;
                  cd_n          = CD_LOAD;
                  x_n           = PARK_XY;
                  y_n           = PARK_XY;
                  hit_pending_n = 1'b0;
               end else begin
                  y_n = BulletY - STEP_V;
               end
            end
         end
         COOLDOWN: begin
            if (frame_tick) begin
               if (cd_cnt == '0) state_n = IDLE;
               else              cd_n    = cd_cnt - 1'b1;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   assign bullet_active = (state == FLYING);

endmodule

// File: tb/tb_bullet_controller.sv
// Directed bench for bullet_controller: launch, climb, top exit, hits,
// cooldown length, held fire, saturated spawn and asynchronous reset.
module tb_bullet_controller;

   logic       Clk = 1'b0;
   logic       Reset;
   logic       frame_clk;
   logic       fire;
   logic       target_hit;
   logic [9:0] ShooterX, ShooterY;
   logic [9:0] BulletX, BulletY;
   logic       bullet_active;
   logic [7:0] shots_fired;

   int passed = 0;
   int total  = 0;

   bullet_controller dut (
      .Clk           (Clk),
      .Reset         (Reset),
      .frame_clk     (frame_clk),
      .fire          (fire),
      .target_hit    (target_hit),
      .ShooterX      (ShooterX),
      .ShooterY      (ShooterY),
      .BulletX       (BulletX),
      .BulletY       (BulletY),
      .bullet_active (bullet_active),
      .shots_fired   (shots_fired)
   );

   always #5 Clk = ~Clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
   endtask

   task automatic check_pos(input string tag, input int x, input int y, input logic act);
      check({tag, ".x"}, 32'(BulletX), 32'(x));
      check({tag, ".y"}, 32'(BulletY), 32'(y));
      check({tag, ".act"}, 32'(bullet_active), 32'(act));
   endtask

   // One vsync period; state has settled by the time this returns.
   task automatic frame();
      @(negedge Clk) frame_clk = 1'b1;
      repeat (4) @(negedge Clk);
      frame_clk = 1'b0;
      repeat (4) @(negedge Clk);
   endtask

   task automatic pulse_fire();
      @(negedge Clk) fire = 1'b1;
      @(negedge Clk) fire = 1'b0;
      @(negedge Clk);
   endtask

   task automatic pulse_hit();
      @(negedge Clk) target_hit = 1'b1;
      @(negedge Clk) target_hit = 1'b0;
      @(negedge Clk);
   endtask

   initial begin
      Reset      = 1'b1;
      frame_clk  = 1'b0;
      fire       = 1'b0;
      target_hit = 1'b0;
      ShooterX   = 10'd100;
      ShooterY   = 10'd200;
      repeat (3) @(negedge Clk);
      check_pos("in_reset", 1000, 1000, 1'b0);
      check("in_reset.shots", 32'(shots_fired), 0);
      Reset = 1'b0;
      @(negedge Clk);

      // Launch and climb
      pulse_fire();
      frame();
      check_pos("launch", 104, 196, 1'b1);
      check("launch.shots", 32'(shots_fired), 1);
      frame();
      check_pos("climb1", 104, 192, 1'b1);
      frame();
      check_pos("climb2", 104, 188, 1'b1);

      // Asynchronous reset mid-flight, observed before any clock edge
      @(negedge Clk);
      #2 Reset = 1'b1;
      #1;
      check_pos("async_reset", 1000, 1000, 1'b0);
      check("async_reset.shots", 32'(shots_fired), 0);
      @(negedge Clk) Reset = 1'b0;
      @(negedge Clk);

      // Top exit, then exact cooldown length
      ShooterY = 10'd10;
      pulse_fire();
      frame();
      check_pos("top.launch", 104, 6, 1'b1);
      check("top.shots", 32'(shots_fired), 1);
      frame();
      check_pos("top.y2", 104, 2, 1'b1);
      frame();
      check_pos("top.retire", 1000, 1000, 1'b0);
      repeat (7) frame();
      pulse_fire();
      frame();
      check_pos("cd.last_tick", 1000, 1000, 1'b0);
      check("cd.fire_ignored", 32'(shots_fired), 1);
      pulse_fire();
      frame();
      check_pos("cd.relaunch", 104, 6, 1'b1);
      check("cd.relaunch.shots", 32'(shots_fired), 2);

      // One-cycle hit between ticks retires on the next tick
      pulse_hit();
      check_pos("hit.before_tick", 104, 6, 1'b1);
      frame();
      check_pos("hit.retire", 1000, 1000, 1'b0);
      pulse_fire();
      frame();
      check_pos("hit.cd_fire", 1000, 1000, 1'b0);
      check("hit.cd_fire.shots", 32'(shots_fired), 2);
      repeat (7) frame();

      // Held fire: one launch, full flight to Y=0, retire, no re-arm
      ShooterY = 10'd200;
      @(negedge Clk) fire = 1'b1;
      @(negedge Clk);
      for (int i = 1; i <= 70; i++) begin
         frame();
         if (i == 1)  check_pos("held.launch", 104, 196, 1'b1);
         if (i == 50) check_pos("held.y0", 104, 0, 1'b1);
         if (i == 51) check_pos("held.retire", 1000, 1000, 1'b0);
      end
      check("held.shots", 32'(shots_fired), 3);
      check_pos("held.end", 1000, 1000, 1'b0);
      @(negedge Clk) fire = 1'b0;

      // Saturated spawn
      ShooterX = 10'd0;
      ShooterY = 10'd2;
      pulse_fire();
      frame();
      check_pos("sat.launch", 4, 0, 1'b1);
      check("sat.shots", 32'(shots_fired), 4);
      frame();
      check_pos("sat.retire", 1000, 1000, 1'b0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/bullet_controller.md
# bullet_controller

Frame-rate motion controller for the single player bullet: it launches on a fire keypress and moves the bullet up the screen once per video frame. It retires the bullet on a hit or when it leaves the top edge, then enforces a cooldown before the next shot. It sits directly upstream of `color_mapper` and drives its `BulletX`/`BulletY` inputs. The shooter position it reads is the same `BallX`/`BallY` that `color_mapper` draws as an 8×16 glyph with its top-left corner at that point.

## Interface
Parameters:
- `STEP`, 4 — pixels the bullet moves up per frame.
- `Y_MIN`, 0 — top retire boundary.
- `COOLDOWN_FRAMES`, 8 — frames spent in COOLDOWN after a retire; must be ≥ 1.
- `PARK_XY`, 10'd1000 — coordinate driven on both axes when no bullet is live; off-screen for a 640×480 raster.

Ports:
- `Clk` — in, 1 — system clock; all state is on its rising edge.
- `Reset` — in, 1 — asynchronous, active-high.
- `frame_clk` — in, 1 — vertical sync; asynchronous to `Clk`.
- `fire` — in, 1 — level, high while the fire key is held.
- `target_hit` — in, 1 — level from collision logic.
- `ShooterX`, `ShooterY` — in, 10 each — shooter glyph top-left corner.
- `BulletX`, `BulletY` — out, 10 each — bullet centre, registered.
- `bullet_active` — out, 1 — high in FLYING only.
- `shots_fired` — out, 8 — launch count; wraps 255→0.

## Operation
- **States:** IDLE, FLYING, COOLDOWN. Every state transition and every position update happens only on a cycle where `frame_tick` = 1.
- **frame_tick:**
  - `frame_clk` passes through a 2-flop synchronizer, then a rising-edge detector.
  - The result is one `Clk` cycle high per frame.
- **fire_pending:**
  - Set on a `fire` rising edge detected in `Clk` (registered previous value) while in IDLE.
  - Cleared on launch.
  - `fire` edges in FLYING or COOLDOWN are discarded.
  - Holding `fire` does not auto-repeat.
- **IDLE:**
  - If `frame_tick` and `fire_pending` → FLYING.
  - On launch: `BulletX = ShooterX + 4`; `BulletY = ShooterY − 4`, saturating at 0 if `ShooterY < 4`.
  - On launch, `shots_fired` increments.
- **FLYING:**
  - `hit_pending` is set whenever `target_hit` is high in FLYING and is sticky until FLYING is exited.
  - On `frame_tick`, if `hit_pending` or `target_hit` → COOLDOWN.
  - Otherwise, if `BulletY < Y_MIN + STEP` → COOLDOWN. This is an unsigned compare, so there is no wrap-around.
  - Otherwise `BulletY −= STEP`; `BulletX` is held.
- **COOLDOWN:**
  - On entry, `cd_cnt` loads `COOLDOWN_FRAMES − 1`.
  - On each tick: if `cd_cnt` = 0 → IDLE, else decrement.
- **Parking:** outside FLYING, `BulletX = BulletY = PARK_XY`, so `color_mapper` draws nothing.
- **Simultaneous events:**
  - A hit and top-edge exit on the same tick take the same path (→ COOLDOWN).
  - A `fire` edge on the same cycle as the IDLE→FLYING tick is not counted as a second shot.
- **Reset (asynchronous, any time, including mid-flight):**
  - State → IDLE.
  - `BulletX`/`BulletY` → `PARK_XY`.
  - `bullet_active` → 0; `shots_fired` → 0.
  - `fire_pending`, `hit_pending`, `cd_cnt`, and all synchronizer and edge registers → 0.

## Timing
- **Tick latency:** `frame_clk` rises before `Clk` edge k. `s1` captures at edge k, `s2` at k+1, and `frame_tick` is high during cycle k+1→k+2. State and outputs update at edge k+2.
- **Launch latency:** a `fire` rising edge must be registered at least one cycle before the tick edge. The bullet then appears at that tick edge, within one frame worst case.
- **Hit-to-retire latency:** at most one frame. A hit pulse as short as 1 `Clk` cycle is never lost.
- **Outputs:** all outputs are registered; there is no combinational path from any input to any output.
- **Shot period:** minimum spacing between launches = flight frames + `COOLDOWN_FRAMES` + 1.

## Structure
- **Package `bullet_pkg`:**
  - `typedef enum logic [1:0] {IDLE, FLYING, COOLDOWN} bullet_state_t`.
  - `localparam` values for `PARK_XY`, the spawn X offset (4) and the spawn Y offset (4).
- **Sub-module `frame_tick_sync`:** synchronizer plus edge detector, with ports `Clk`, `Reset`, `frame_clk` → `frame_tick`. It is intended for reuse by the shooter and enemy motion blocks.

## Test plan
- **Reset:** assert `Reset` mid-cycle → `BulletX`/`BulletY` = 1000 and `bullet_active` = 0 immediately (asynchronous); `shots_fired` = 0.
- **Launch and climb:** `ShooterX`=100, `ShooterY`=200; pulse `fire`; run ticks → first tick gives (104, 196), `shots_fired`=1; next ticks give Y = 192, 188, ….
- **Top exit:** launch with `ShooterY`=10 → Y = 6, then 2. The next tick retires (2 < 4), outputs park, and after 8 more ticks state = IDLE.
- **Short hit pulse:** 1-cycle `target_hit` between ticks while FLYING → park on the next tick; a `fire` edge during COOLDOWN is ignored (no launch, `shots_fired` unchanged).
- **Held fire:** `fire` held high for 50 frames → exactly one launch.
- **Saturated spawn:** `ShooterY`=2 with a pending fire → launch at Y = 0, retire on the following tick.
